// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one uart_tx serializer between two byte requesters.
// Optional stall watchdog: define ARB_WATCHDOG_EN to enable it (otherwise wd_err is tied low).
module uart_tx_arbiter #(
    parameter int MAX_BURST    = 16,
    parameter int WATCHDOG_CYC = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic [1:0] grant,
    output logic       idle,
    output logic       wd_err
);
    // state     | meaning
    // S_IDLE    | no owner; pick a winner among valid requesters
    // S_LOAD    | owner's ready is high; capture the next byte
    // S_START   | one-cycle start pulse to the serializer
    // S_WAIT_HI | waiting for the serializer to report busy
    // S_WAIT_LO | byte on the wire; on busy falling decide keep or release
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("uart_tx_arbiter: MAX_BURST must be in 1..255");
    end
    if (WATCHDOG_CYC < 1 || WATCHDOG_CYC > 65535) begin : g_bad_wd
        $error("uart_tx_arbiter: WATCHDOG_CYC must be in 1..65535");
    end

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       last_q, last_d;
    logic       wd_fire;

    logic       own1;
    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       other_valid;
    logic       at_limit;

    assign own1        = grant_q[1];
    assign sel_valid   = own1 ? req1_valid : req0_valid;
    assign sel_data    = own1 ? req1_data  : req0_data;
    assign sel_last    = own1 ? req1_last  : req0_last;
    assign other_valid = own1 ? req0_valid : req1_valid;
    assign at_limit    = (burst_cnt_q == BURST_LIM);

`ifdef ARB_WATCHDOG_EN
    localparam logic [15:0] WD_LIM = 16'(WATCHDOG_CYC);

    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        wd_err_q;
    logic        stall;

    assign stall = (state_q == S_LOAD) && !sel_valid;

    always_comb begin
        wd_cnt_d = 16'd0;
        if (stall) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end
    end

    assign wd_fire = stall && (wd_cnt_d == WD_LIM);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wd_cnt_q <= 16'd0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_fire ? 16'd0 : wd_cnt_d;
            wd_err_q <= wd_fire;
        end
    end

    assign wd_err = wd_err_q;
`else
    assign wd_fire = 1'b0;
    assign wd_err  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        tx_data_d   = tx_data_q;
        last_d      = last_q;
        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_d = S_LOAD;
                    if (req0_valid && req1_valid) begin
                        grant_d = rr_ptr_q ? 2'b10 : 2'b01;
                    end else begin
                        grant_d = req0_valid ? 2'b01 : 2'b10;
                    end
                end
            end
            S_LOAD: begin
                if (sel_valid) begin
                    tx_data_d   = sel_data;
                    last_d      = sel_last;
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    state_d     = S_START;
                end else if (wd_fire) begin
                    grant_d     = 2'b00;
                    rr_ptr_d    = ~own1;
                    burst_cnt_d = 8'd0;
                    state_d     = S_IDLE;
                end
            end
            S_START: begin
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    // a full burst only yields the link if someone else is actually waiting
                    if (last_q || (at_limit && other_valid)) begin
                        grant_d     = 2'b00;
                        rr_ptr_d    = ~own1;
                        burst_cnt_d = 8'd0;
                        state_d     = S_IDLE;
                    end else begin
                        if (at_limit) begin
                            burst_cnt_d = 8'd0;
                        end
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'b00;
            rr_ptr_q    <= 1'b0;
            burst_cnt_q <= 8'd0;
            tx_data_q   <= 8'h00;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            tx_data_q   <= tx_data_d;
            last_q      <= last_d;
        end
    end

    assign req0_ready = (state_q == S_LOAD) && grant_q[0];
    assign req1_ready = (state_q == S_LOAD) && grant_q[1];
    assign tx_start   = (state_q == S_START);
    assign tx_data    = tx_data_q;
    assign grant      = grant_q;
    assign idle       = (state_q == S_IDLE);

endmodule
